button_conditioner: RTL and testbench

- Front-end stage for the game-board controller: cleans the seven raw push-button inputs and feeds the button encoder and move-delay stage.
- Button bit order is {reset_blue, reset_red, decision, up, down, left, right}, bits 6 to 0.
- Provides synchronised, debounced button levels.
- Provides single-cycle press pulses, with at most one pulse bit high per cycle.
- Provides hold-to-repeat pulses for the four direction buttons, so a held direction steps the cursor continuously.

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-bit debounce, press-pulse
// arbitration (highest index wins) and hold-to-repeat for the direction buttons.
module button_conditioner #(
    parameter int               N_BTN           = 7,
    parameter int               DEBOUNCE_CYCLES = 500_000,
    parameter int               REPEAT_DELAY    = 50_000_000,
    parameter int               REPEAT_RATE     = 25_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 7'b000_1111
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic             o_repeat_active
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int IDX_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    localparam logic [DB_W-1:0]  DB_MAX      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DLY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LD = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] r_level_prev;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] r_pulse;
    logic [N_BTN-1:0] w_pulse_next;

    logic             w_rise_any;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_masked;
    logic             w_rpt_fire;

    state_t           r_state;
    state_t           w_state_next;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_debounce
        logic [DB_W-1:0] r_db_cnt;
        logic            r_lvl;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_db_cnt <= '0;
                r_lvl    <= 1'b0;
            end else if (r_sync2[gi] == r_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_lvl    <= r_sync2[gi];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end

        assign w_level[gi] = r_lvl;
    end

    assign w_rise = w_level & ~r_level_prev;

    // Highest-index rising button wins; others in the same cycle are dropped.
    always_comb begin
        w_rise_any = 1'b0;
        w_win_idx  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_rise[i]) begin
                w_rise_any = 1'b1;
                w_win_idx  = IDX_W'(i);
            end
        end
    end

    assign w_win_masked = w_rise_any && REPEAT_MASK[w_win_idx];

    always_comb begin
        w_state_next   = r_state;
        w_rpt_cnt_next = r_rpt_cnt;
        w_idx_next     = r_idx;
        w_rpt_fire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_masked) begin
                    w_idx_next     = w_win_idx;
                    w_rpt_cnt_next = RPT_DLY_LD;
                    w_state_next   = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (w_win_masked) begin
                    w_idx_next     = w_win_idx;
                    w_rpt_cnt_next = RPT_DLY_LD;
                    w_state_next   = ST_DELAY;
                end else if (!w_level[r_idx]) begin
                    w_state_next = ST_IDLE;
                end else if (r_rpt_cnt == '0) begin
                    w_rpt_fire     = 1'b1;
                    w_rpt_cnt_next = RPT_RATE_LD;
                    w_state_next   = ST_REPEAT;
                end else begin
                    w_rpt_cnt_next = r_rpt_cnt - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A fresh press always takes the pulse slot over a coincident repeat.
    always_comb begin
        w_pulse_next = '0;
        if (w_rise_any) begin
            w_pulse_next[w_win_idx] = 1'b1;
        end else if (w_rpt_fire) begin
            w_pulse_next[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_rpt_cnt    <= '0;
            r_idx        <= '0;
            r_pulse      <= '0;
            r_level_prev <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rpt_cnt    <= w_rpt_cnt_next;
            r_idx        <= w_idx_next;
            r_pulse      <= w_pulse_next;
            r_level_prev <= w_level;
        end
    end

    assign o_btn_level     = w_level;
    assign o_btn_pulse     = r_pulse;
    assign o_repeat_active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

    logic       clk;
    logic       reset_n;
    logic [6:0] btn_raw;
    logic [6:0] btn_level;
    logic [6:0] btn_pulse;
    logic       repeat_active;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .N_BTN           (7),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (5),
        .REPEAT_MASK     (7'b000_1111)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_btn_raw       (btn_raw),
        .o_btn_level     (btn_level),
        .o_btn_pulse     (btn_pulse),
        .o_repeat_active (repeat_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_raw = '0;
        tick();
        tick();
        checks++;
        if (btn_level !== 7'b0) begin
            $display("FAIL reset_level actual=%b required=%b", btn_level, 7'b0);
            failures++;
        end
        checks++;
        if (btn_pulse !== 7'b0) begin
            $display("FAIL reset_pulse actual=%b required=%b", btn_pulse, 7'b0);
            failures++;
        end
        checks++;
        if (repeat_active !== 1'b0) begin
            $display("FAIL reset_ra actual=%b required=0", repeat_active);
            failures++;
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (btn_pulse !== 7'b0 || btn_level !== 7'b0) begin
            $display("FAIL post_reset_idle actual=%b/%b required=0/0", btn_level, btn_pulse);
            failures++;
        end
        $display("test_reset done");
    endtask

    task automatic test_glitch();
        btn_raw = 7'b000_1000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (btn_level !== 7'b0 || btn_pulse !== 7'b0 || repeat_active !== 1'b0) begin
                $display("FAIL glitch k=%0d actual=%b/%b/%b required=0/0/0",
                         k, btn_level, btn_pulse, repeat_active);
                failures++;
            end
            if (k == 3) btn_raw = '0;
        end
        $display("test_glitch done");
    endtask

    task automatic test_press_no_repeat();
        logic [6:0] exp_l;
        logic [6:0] exp_p;
        btn_raw = 7'b001_0000;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_l = (k >= 6 && k <= 25) ? 7'b001_0000 : 7'b0;
            exp_p = (k == 7) ? 7'b001_0000 : 7'b0;
            checks++;
            if (btn_level !== exp_l) begin
                $display("FAIL decision_level k=%0d actual=%b required=%b", k, btn_level, exp_l);
                failures++;
            end
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL decision_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== 1'b0) begin
                $display("FAIL decision_ra k=%0d actual=%b required=0", k, repeat_active);
                failures++;
            end
            if (k == 20) btn_raw = '0;
        end
        $display("test_press_no_repeat done");
    endtask

    task automatic test_repeat();
        logic [6:0] exp_l;
        logic [6:0] exp_p;
        logic       exp_ra;
        btn_raw = 7'b000_0010;
        for (int k = 1; k <= 45; k++) begin
            tick();
            exp_l  = (k >= 6 && k <= 33) ? 7'b000_0010 : 7'b0;
            exp_p  = (k == 7 || k == 17 || k == 22 || k == 27 || k == 32) ? 7'b000_0010 : 7'b0;
            exp_ra = (k >= 7 && k <= 34);
            checks++;
            if (btn_level !== exp_l) begin
                $display("FAIL left_level k=%0d actual=%b required=%b", k, btn_level, exp_l);
                failures++;
            end
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL left_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== exp_ra) begin
                $display("FAIL left_ra k=%0d actual=%b required=%b", k, repeat_active, exp_ra);
                failures++;
            end
            if (k == 28) btn_raw = '0;
        end
        $display("test_repeat done");
    endtask

    task automatic test_arbitration();
        logic [6:0] exp_l;
        logic [6:0] exp_p;
        logic       exp_ra;
        btn_raw = 7'b010_0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_l = (k >= 6 && k <= 13) ? 7'b010_0001 : 7'b0;
            exp_p = (k == 7) ? 7'b010_0000 : 7'b0;
            checks++;
            if (btn_level !== exp_l) begin
                $display("FAIL arb_level k=%0d actual=%b required=%b", k, btn_level, exp_l);
                failures++;
            end
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL arb_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== 1'b0) begin
                $display("FAIL arb_ra k=%0d actual=%b required=0", k, repeat_active);
                failures++;
            end
            if (k == 8) btn_raw = '0;
        end
        btn_raw = 7'b000_0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_p  = (k == 7) ? 7'b000_0001 : 7'b0;
            exp_ra = (k >= 7 && k <= 14);
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL repress_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== exp_ra) begin
                $display("FAIL repress_ra k=%0d actual=%b required=%b", k, repeat_active, exp_ra);
                failures++;
            end
            if (k == 8) btn_raw = '0;
        end
        $display("test_arbitration done");
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_l;
        logic [6:0] exp_p;
        logic       exp_ra;
        btn_raw = 7'b000_0100;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp_l = ((k >= 6 && k <= 50) ? 7'b000_0100 : 7'b0)
                  | ((k >= 26 && k <= 50) ? 7'b000_1000 : 7'b0);
            if (k == 7 || k == 17 || k == 22)
                exp_p = 7'b000_0100;
            else if (k == 27 || k == 37 || k == 42 || k == 47)
                exp_p = 7'b000_1000;
            else
                exp_p = 7'b0;
            exp_ra = (k >= 7 && k <= 51);
            checks++;
            if (btn_level !== exp_l) begin
                $display("FAIL retarget_level k=%0d actual=%b required=%b", k, btn_level, exp_l);
                failures++;
            end
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL retarget_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== exp_ra) begin
                $display("FAIL retarget_ra k=%0d actual=%b required=%b", k, repeat_active, exp_ra);
                failures++;
            end
            if (k == 20) btn_raw = 7'b000_1100;
            if (k == 45) btn_raw = '0;
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_hold();
        logic [6:0] exp_l;
        logic [6:0] exp_p;
        logic       exp_ra;
        btn_raw = 7'b000_1000;
        for (int k = 1; k <= 20; k++) tick();
        checks++;
        if (repeat_active !== 1'b1) begin
            $display("FAIL hold_ra_before_reset actual=%b required=1", repeat_active);
            failures++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (btn_level !== 7'b0 || btn_pulse !== 7'b0 || repeat_active !== 1'b0) begin
            $display("FAIL midhold_reset actual=%b/%b/%b required=0/0/0",
                     btn_level, btn_pulse, repeat_active);
            failures++;
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_l  = (k >= 6 && k <= 30) ? 7'b000_1000 : 7'b0;
            exp_p  = (k == 7 || k == 17 || k == 22 || k == 27) ? 7'b000_1000 : 7'b0;
            exp_ra = (k >= 7 && k <= 31);
            checks++;
            if (btn_level !== exp_l) begin
                $display("FAIL after_reset_level k=%0d actual=%b required=%b", k, btn_level, exp_l);
                failures++;
            end
            checks++;
            if (btn_pulse !== exp_p) begin
                $display("FAIL after_reset_pulse k=%0d actual=%b required=%b", k, btn_pulse, exp_p);
                failures++;
            end
            checks++;
            if (repeat_active !== exp_ra) begin
                $display("FAIL after_reset_ra k=%0d actual=%b required=%b", k, repeat_active, exp_ra);
                failures++;
            end
            if (k == 25) btn_raw = '0;
        end
        $display("test_reset_mid_hold done");
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = '0;
        test_reset();
        test_glitch();
        test_press_no_repeat();
        test_repeat();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
